// File: rtl/dadda_pkg.sv
// Shared types and widths for the Dadda multiplier and the MAC accumulator built on it.
package dadda_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        OUT
    } mac_state_t;

    typedef struct packed {
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
    } csa_t;

    // 3:2 carry-save compressor over whole rows; carries out of the top bit are dropped
    // because the final product always fits in PROD_W bits.
    function automatic csa_t csa(input logic [PROD_W-1:0] x,
                                 input logic [PROD_W-1:0] y,
                                 input logic [PROD_W-1:0] z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/dadda.sv
// Combinational unsigned 8x8 multiplier: partial-product rows reduced along the
// Dadda height sequence 8 -> 6 -> 4 -> 3 -> 2, then a single carry-propagate add.
module dadda
    import dadda_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] p_o
);

    logic [PROD_W-1:0] pp [OP_W];

    genvar gi;
    generate
        for (gi = 0; gi < OP_W; gi++) begin : g_pp
            assign pp[gi] = {{OP_W{1'b0}}, a_i & {OP_W{b_i[gi]}}} << gi;
        end
    endgenerate

    csa_t s1a, s1b, s2a, s2b, s3, s4;

    assign s1a = csa(pp[0], pp[1], pp[2]);
    assign s1b = csa(pp[3], pp[4], pp[5]);
    assign s2a = csa(s1a.s, s1a.c, s1b.s);
    assign s2b = csa(s1b.c, pp[6], pp[7]);
    assign s3  = csa(s2a.s, s2a.c, s2b.s);
    assign s4  = csa(s3.s, s3.c, s2b.c);

    assign p_o = s4.s + s4.c;

endmodule

// File: rtl/dadda_mac_acc.sv
// Three-stage multiply-accumulate: operand register, product register, saturating
// frame accumulator, with the frame total held on a valid/ready result port.
module dadda_mac_acc
    import dadda_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    mac_state_t        state_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [OP_W-1:0]   a_q, b_q;
    logic              v1_q, l1_q;
    logic [PROD_W-1:0] p_d, p_q;
    logic              v2_q, l2_q;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W:0]    sum_wide;

    logic [ACC_W-1:0]  out_sum_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic              out_ovf_q;

    logic              accept;
    logic              frame_end;

    assign accept    = in_valid & in_ready_q;
    assign frame_end = v2_q & l2_q;

    dadda u_dadda (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (p_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            l1_q <= 1'b0;
            p_q  <= '0;
            v2_q <= 1'b0;
            l2_q <= 1'b0;
        end else begin
            v1_q <= accept;
            l1_q <= accept & in_last;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            p_q  <= p_d;
            v2_q <= v1_q;
            l2_q <= v1_q & l1_q;
        end
    end

    always_comb begin
        sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_q};
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (v2_q) begin
            if (sum_wide[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_wide[ACC_W-1:0];
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The closing beat's contribution goes straight to the result registers while the
    // running state is cleared for the next frame on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else if (frame_end) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= acc_d;
            out_cnt_q <= cnt_d;
            out_ovf_q <= ovf_d;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept && in_last) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (frame_end) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= ACC;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Bench for dadda_mac_acc: a 24-bit and a 16-bit accumulator instance share one stimulus
// stream and are checked every cycle against a frame-level model plus literal results.
module tb_dadda_mac_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [23:0] out_sum_a;
    logic [7:0]  out_cnt_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [15:0] out_sum_b;
    logic [7:0]  out_cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dadda_mac_acc #(.ACC_W(24), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(out_sum_a), .out_cnt(out_cnt_a), .out_ovf(out_ovf_a)
    );

    dadda_mac_acc #(.ACC_W(16), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_cnt(out_cnt_b), .out_ovf(out_ovf_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: sum exact products per frame, clamp at the end, and release
    // the result three cycles after the closing beat is accepted.
    bit     m_ready = 1'b1;
    bit     m_valid = 1'b0;
    longint f_sum = 0;
    int     f_cnt = 0;
    int     cd = 0;
    longint pend_sum = 0;
    int     pend_cnt = 0;
    longint m_sum_a = 0;
    longint m_sum_b = 0;
    int     m_cnt = 0;
    bit     m_ovf_a = 1'b0;
    bit     m_ovf_b = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy0, val0;
        if (!rst_n) begin
            m_ready = 1'b1; m_valid = 1'b0; f_sum = 0; f_cnt = 0; cd = 0;
            m_sum_a = 0; m_sum_b = 0; m_cnt = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
        end else begin
            rdy0 = m_ready;
            val0 = m_valid;
            if (val0 && out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    m_valid = 1'b1;
                    m_sum_a = (pend_sum > 64'd16777215) ? 64'd16777215 : pend_sum;
                    m_ovf_a = (pend_sum > 64'd16777215);
                    m_sum_b = (pend_sum > 64'd65535) ? 64'd65535 : pend_sum;
                    m_ovf_b = (pend_sum > 64'd65535);
                    m_cnt   = (pend_cnt > 255) ? 255 : pend_cnt;
                end
            end
            if (rdy0 && in_valid) begin
                f_sum += longint'(in_a) * longint'(in_b);
                f_cnt++;
                if (in_last) begin
                    pend_sum = f_sum;
                    pend_cnt = f_cnt;
                    f_sum = 0;
                    f_cnt = 0;
                    m_ready = 1'b0;
                    cd = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready_a", in_ready_a, m_ready);
            chk("cyc_in_ready_b", in_ready_b, m_ready);
            chk("cyc_out_valid_a", out_valid_a, m_valid);
            chk("cyc_out_valid_b", out_valid_b, m_valid);
            chk("cyc_out_sum_a", out_sum_a, m_sum_a);
            chk("cyc_out_sum_b", out_sum_b, m_sum_b);
            chk("cyc_out_cnt_a", out_cnt_a, m_cnt);
            chk("cyc_out_cnt_b", out_cnt_b, m_cnt);
            chk("cyc_out_ovf_a", out_ovf_a, m_ovf_a);
            chk("cyc_out_ovf_b", out_ovf_b, m_ovf_b);
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        bit ok;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 60 cycles");
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_result(input string name, input int lat,
                               input longint sa, input int cnt, input bit ova,
                               input longint sb, input bit ovb);
        int  n;
        bit  got;
        n = 0; got = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid_a) begin
                n = i; got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1 within 40 cycles", name);
        end else begin
            chk({name, "_latency"}, n, lat);
            chk({name, "_sum_a"}, out_sum_a, sa);
            chk({name, "_cnt_a"}, out_cnt_a, cnt);
            chk({name, "_ovf_a"}, out_ovf_a, ova);
            chk({name, "_sum_b"}, out_sum_b, sb);
            chk({name, "_cnt_b"}, out_cnt_b, cnt);
            chk({name, "_ovf_b"}, out_ovf_b, ovb);
            $display("frame %s: sum24=%0d cnt=%0d ovf24=%0d sum16=%0d ovf16=%0d latency=%0d",
                     name, out_sum_a, out_cnt_a, out_ovf_a, out_sum_b, out_ovf_b, n);
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_sum", out_sum_a, 0);
        chk("rst_out_cnt", out_cnt_a, 0);
        chk("rst_out_ovf", out_ovf_a, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(8'd255, 8'd255, 1'b1);
        wait_result("single", 3, 65025, 1, 0, 65025, 0);

        send(8'd3, 8'd4, 1'b0);
        send(8'd10, 8'd20, 1'b0);
        send(8'd0, 8'd255, 1'b0);
        send(8'd128, 8'd2, 1'b1);
        wait_result("four", 3, 468, 4, 0, 468, 0);

        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        wait_result("sat16", 3, 130050, 2, 0, 65535, 1);
        send(8'd1, 8'd1, 1'b1);
        wait_result("after_sat", 3, 1, 1, 0, 1, 0);

        send(8'd2, 8'd3, 1'b0);
        idle(2);
        send(8'd4, 8'd5, 1'b1);
        wait_result("bubbles", 3, 26, 2, 0, 26, 0);

        for (int i = 0; i < 259; i++) send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        wait_result("sat24", 3, 16777215, 255, 1, 65535, 1);

        out_ready = 1'b0;
        send(8'd5, 8'd6, 1'b1);
        wait_result("hold", 3, 30, 1, 0, 30, 0);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready_a, 0);
            chk("hold_out_valid", out_valid_a, 1);
            chk("hold_out_sum", out_sum_a, 30);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_hs_in_ready", in_ready_a, 1);
        chk("post_hs_out_valid", out_valid_a, 0);
        send(8'd9, 8'd9, 1'b1);
        wait_result("after_hold", 3, 81, 1, 0, 81, 0);

        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_sum", out_sum_a, 0);
        chk("midrst_out_cnt", out_cnt_a, 0);
        chk("midrst_out_valid", out_valid_a, 0);
        chk("midrst_in_ready", in_ready_a, 1);
        chk("midrst_out_sum_b", out_sum_b, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'd7, 8'd7, 1'b1);
        wait_result("after_rst", 3, 49, 1, 0, 49, 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dadda_mac_acc.md
# dadda_mac_acc

Sequential multiply-accumulate stage built around the team's combinational 8x8 `dadda` multiplier. It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and registers each pair into the multiplier. It registers the 16-bit product and sums the products of one frame, which ends with the beat marked `in_last`, into a saturating accumulator. It then presents the frame total, beat count and overflow flag on an output valid/ready handshake.

## Interface
- `ACC_W`, 24: accumulator and result width; legal range 16..32.
- `CNT_W`, 8: beat-count width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_a` input 8: unsigned multiplicand.
- `in_b` input 8: unsigned multiplier.
- `in_last` input 1: final beat of the frame.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output ACC_W: saturated sum of the frame's products.
- `out_cnt` output CNT_W: beats in the frame, saturating.
- `out_ovf` output 1: the sum saturated in this frame.

## Operation
- FSM states:
  - ACC: `in_ready` = 1.
  - DRAIN: `in_ready` = 0; the last beat is in the pipeline.
  - OUT: `in_ready` = 0; `out_valid` = 1.
- FSM transitions:
  - ACC -> DRAIN on an accepted beat with `in_last` = 1.
  - DRAIN -> OUT when the last-tagged product is accumulated.
  - OUT -> ACC on `out_valid` & `out_ready`.
- Pipeline:
  - S1 holds `a_q`, `b_q`, `v1`, `l1`; it loads on `in_valid` & `in_ready`.
  - S2 holds `p_q` = `dadda(a_q, b_q)`, plus `v2` and `l2`.
  - S3 is the accumulator `acc`, the count `cnt` and the flag `ovf`.
- Accumulate when `v2` = 1:
  - Compute `acc` + `p_q` in ACC_W+1 bits.
  - If the result exceeds 2^ACC_W-1, clamp to 2^ACC_W-1 and set `ovf` (sticky).
  - Increment `cnt`, saturating at 2^CNT_W-1.
- When `v2` & `l2`:
  - Load the final sum, count and flag into `out_sum`, `out_cnt`, `out_ovf`.
  - Clear `acc`, `cnt` and `ovf` to 0 in the same edge.
- Bubbles (`in_valid` = 0) clear `v1`; they add nothing and do not count.
- A zero product still counts as a beat.
- The output registers hold stable while `out_valid` = 1 and `out_ready` = 0.
- A frame of one beat (`in_last` on the first beat) is legal.

## Timing
- Reset values: `in_ready` = 1 (state ACC), `out_valid` = 0, `out_sum` = 0, `out_cnt` = 0, `out_ovf` = 0. All of `v1`, `v2`, `acc`, `cnt` and `ovf` reset to 0.
- A beat accepted in cycle t:
  - Operands registered at the end of t.
  - Product registered at the end of t+1.
  - Accumulated at the end of t+2.
- If the beat at t carries `in_last`, `out_valid` = 1 from cycle t+3.
- Throughput is one beat per cycle within a frame.
- The frame-to-frame gap is at least 4 cycles: the last-beat latency plus one cycle in OUT.
- `out_valid` rises in the cycle after DRAIN exits. The result handshake completes on any edge with `out_valid` & `out_ready`, and the next cycle `in_ready` = 1.
- `in_ready` is registered state only; it has no combinational path from `out_ready`.
- `rst_n` low asserts asynchronously and resets all state, including mid-frame. A partial frame is discarded and no `out_valid` is produced for it. Deassertion is synchronous to `clk` externally.

## Structure
- Package `dadda_pkg`:
  - State enum `mac_state_t` {ACC, DRAIN, OUT}.
  - Localparams `OP_W` = 8 and `PROD_W` = 16.
- Sub-module: a single instance of the existing `dadda` multiplier between S1 and S2; no other hierarchy.
- The saturating add is inline.

## Test plan
- Single beat 255×255 with `in_last`, `out_ready` = 1: `out_valid` at t+3, `out_sum` = 65025, `out_cnt` = 1, `out_ovf` = 0.
- Frame (3,4), (10,20), (0,255), (128,2) on back-to-back cycles: `out_sum` = 468, `out_cnt` = 4, `in_ready` low from t+1 through OUT.
- ACC_W = 16, frame (255,255), (255,255): `out_sum` = 65535, `out_ovf` = 1. The next frame (1,1) gives `out_sum` = 1, `out_ovf` = 0.
- `out_ready` held low 10 cycles with `in_valid` = 1: `out_*` stable, `in_ready` = 0, no beat accepted. After the handshake, a new frame starts with `acc` = 0.
- Frame with bubbles between beats (2,3), gap, gap, (4,5)-last: `out_sum` = 26, `out_cnt` = 2.
- `rst_n` pulsed low mid-frame after 2 beats: all outputs reset immediately. A following frame (7,7)-last yields `out_sum` = 49, `out_cnt` = 1.
